// File: rtl/cis_frame_sequencer.sv
// -----------------------------------------------------------------------------
// cis_frame_sequencer
//
// Sequences one CMOS image sensor frame: a single row-reset pulse, then per row
// an exposure window, an integration trigger to the CIS pattern controller, a
// handshake on the controller's running flag and a row-advance strobe. In
// global-shutter mode the exposure happens once per frame; in rolling mode it
// is repeated before every row.
//
// Optional feature: define CIS_SEQ_TIMEOUT_EN to bound the time spent waiting
// on the running flag (sticky err, frame abandoned). Without it the waits are
// unbounded and err is tied low.
//
// Ports
//   clk            in   single clock
//   reset          in   asynchronous active-high reset
//   start          in   begin a frame (sampled in IDLE only)
//   abort          in   abandon the frame in progress
//   global_shutter in   1 = expose once per frame, 0 = expose before every row
//   num_rows       in   rows per frame (latched on accepted start)
//   exposure_ticks in   exposure length in cycles (latched on accepted start)
//   running        in   busy flag from the CIS pattern controller
//   integration    out  trigger to the CIS pattern controller
//   row_rst        out  row-reset strobe
//   row_clk        out  row-advance strobe
//   row_addr       out  current row
//   busy           out  high whenever the sequencer is not idle
//   frame_done     out  one-cycle pulse at the end of a complete frame
//   frame_count    out  completed frames, wraps 65535 -> 0
//   err            out  sticky timeout flag
// -----------------------------------------------------------------------------
module cis_frame_sequencer #(
    parameter int ROW_W       = 10,
    parameter int EXP_W       = 16,
    parameter int TRIG_CYC    = 10,
    parameter int ROW_RST_CYC = 4,
    parameter int ROW_CLK_CYC = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             global_shutter,
    input  logic [ROW_W-1:0] num_rows,
    input  logic [EXP_W-1:0] exposure_ticks,
    input  logic             running,
    output logic             integration,
    output logic             row_rst,
    output logic             row_clk,
    output logic [ROW_W-1:0] row_addr,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frame_count,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE, ROWRST, EXPOSE, TRIG, WAIT_RUN, WAIT_DONE, ROW_ADV, DONE
    } state_t;

    // One shared counter times every fixed-length state, so it must hold both
    // the longest strobe and the longest exposure.
    localparam int PULSE_MAX = (TRIG_CYC > ROW_RST_CYC)
                             ? ((TRIG_CYC > ROW_CLK_CYC) ? TRIG_CYC : ROW_CLK_CYC)
                             : ((ROW_RST_CYC > ROW_CLK_CYC) ? ROW_RST_CYC : ROW_CLK_CYC);
    localparam int PULSE_W   = $clog2(PULSE_MAX + 1);
    localparam int CNT_W     = (EXP_W > PULSE_W) ? EXP_W : PULSE_W;

    if (TRIG_CYC < 2 || ROW_RST_CYC < 1 || ROW_CLK_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cis_frame_sequencer: pulse widths and timeout must be positive, TRIG_CYC >= 2");
    end

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] rows_q;
    logic [EXP_W-1:0] exp_q;
    logic             gs_q;

    logic start_ok, last_row, exp_last, pulse_state, row_adv_fire, tmo_fire;
    logic integration_d, row_rst_d, row_clk_d, busy_d, frame_done_d;

    // abort beats start even in IDLE; an empty frame is never started.
    assign start_ok     = start && !abort && (num_rows != '0);
    assign last_row     = (row_addr == rows_q - ROW_W'(1));
    // A zero exposure still spends one cycle in EXPOSE.
    assign exp_last     = (exp_q == '0) || (cnt == CNT_W'(exp_q - EXP_W'(1)));
    assign pulse_state  = (state == ROWRST) || (state == EXPOSE) ||
                          (state == TRIG)   || (state == ROW_ADV);
    assign row_adv_fire = (state == ROW_ADV) && !last_row && !abort &&
                          (cnt == CNT_W'(ROW_CLK_CYC - 1));

`ifdef CIS_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Fires on the last allowed cycle of a wait only if the wait is not being
    // satisfied (or aborted) in that same cycle.
    assign tmo_fire = !abort && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) &&
                      (((state == WAIT_RUN) && !running) ||
                       ((state == WAIT_DONE) && running));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state_next != state)
                tmo_cnt <= '0;
            else if ((state == WAIT_RUN) || (state == WAIT_DONE))
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            if ((state == IDLE) && start_ok)
                err <= 1'b0;
            else if (tmo_fire)
                err <= 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign err      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps unlisted
        // paths from inferring latches.
        state_next = state;
        unique case (state)
            IDLE:      if (start_ok) state_next = ROWRST;
            ROWRST:    if (cnt == CNT_W'(ROW_RST_CYC - 1)) state_next = EXPOSE;
            EXPOSE:    if (exp_last) state_next = TRIG;
            TRIG:      if (cnt == CNT_W'(TRIG_CYC - 1)) state_next = WAIT_RUN;
            WAIT_RUN:  if (running) state_next = WAIT_DONE;
                       else if (tmo_fire) state_next = IDLE;
            WAIT_DONE: if (!running) state_next = ROW_ADV;
                       else if (tmo_fire) state_next = IDLE;
            ROW_ADV:   if (last_row) state_next = DONE;
                       else if (cnt == CNT_W'(ROW_CLK_CYC - 1))
                           state_next = gs_q ? TRIG : EXPOSE;
            DONE:      state_next = IDLE;
        endcase
        if (abort && (state != IDLE))
            state_next = IDLE;
    end

    // Output decode from the next state; the result is registered below so
    // every output comes straight from a flop.
    always_comb begin
        integration_d = (state_next == TRIG);
        row_rst_d     = (state_next == ROWRST);
        // row_addr only changes on the edge that leaves ROW_ADV, so the
        // current last_row is valid for every cycle spent there.
        row_clk_d     = (state_next == ROW_ADV) && !last_row;
        busy_d        = (state_next != IDLE);
        frame_done_d  = (state_next == DONE);
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            rows_q      <= '0;
            exp_q       <= '0;
            gs_q        <= 1'b0;
            row_addr    <= '0;
            frame_count <= '0;
            integration <= 1'b0;
            row_rst     <= 1'b0;
            row_clk     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (state_next != state)
                cnt <= '0;
            else if (pulse_state)
                cnt <= cnt + CNT_W'(1);

            // Frame configuration is frozen at start; later input changes
            // cannot disturb the frame in progress.
            if ((state == IDLE) && start_ok) begin
                rows_q   <= num_rows;
                exp_q    <= exposure_ticks;
                gs_q     <= global_shutter;
                row_addr <= '0;
            end else if (row_adv_fire) begin
                row_addr <= row_addr + ROW_W'(1);
            end

            if (state_next == DONE)
                frame_count <= frame_count + 16'd1;

            integration <= integration_d;
            row_rst     <= row_rst_d;
            row_clk     <= row_clk_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule
